// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, shared-ALU and response signals of alu_share_arbiter
interface alu_share_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic [6*NREQ-1:0] req_ctrl;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0] alu_ctrl;
  logic [15:0] alu_out;
  logic alu_zr;
  logic alu_ng;
  logic rsp_valid;
  logic rsp_ready;
  logic [2:0] rsp_id;
  logic [15:0] rsp_data;
  logic rsp_zr;
  logic rsp_ng;
  logic busy;
  modport slave (
    input req_valid, req_x, req_y, req_ctrl, alu_out, alu_zr, alu_ng, rsp_ready,
    output req_ready, alu_x, alu_y, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, busy
  );
  modport master (
    output req_valid, req_x, req_y, req_ctrl, alu_out, alu_zr, alu_ng, rsp_ready,
    input req_ready, alu_x, alu_y, alu_ctrl, rsp_valid, rsp_id, rsp_data, rsp_zr, rsp_ng, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin time-sharing of one Hack ALU among NREQ requesters
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst_n,
  alu_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [PW-1:0] gnt, idx;
  logic gnt_vld;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic valid_q, valid_d;
  logic [2:0] id_q, id_d;
  logic [15:0] data_q, data_d;
  logic zr_q, zr_d;
  logic ng_q, ng_d;
  logic busy_q, busy_d;
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    ctrl_d = ctrl_q;
    valid_d = valid_q;
    id_d = id_q;
    data_d = data_q;
    zr_d = zr_q;
    ng_d = ng_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        state_d = EXEC;
        gnt_d = gnt;
        cnt_d = 4'(SETTLE - 1);
        x_d = bus.req_x[16*gnt +: 16];
        y_d = bus.req_y[16*gnt +: 16];
        ctrl_d = bus.req_ctrl[6*gnt +: 6];
      end
      EXEC: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = RESP;
        valid_d = 1'b1;
        id_d = 3'(gnt_q);
        data_d = bus.alu_out;
        zr_d = bus.alu_zr;
        ng_d = bus.alu_ng;
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        rr_ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
        x_d = '0;
        y_d = '0;
        ctrl_d = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      ctrl_q <= '0;
      valid_q <= 1'b0;
      id_q <= '0;
      data_q <= '0;
      zr_q <= 1'b0;
      ng_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      id_q <= id_d;
      data_q <= data_d;
      zr_q <= zr_d;
      ng_q <= ng_d;
      busy_q <= busy_d;
    end
  end
  assign bus.req_ready = (rst_n && state_q == IDLE && gnt_vld) ? NREQ'(1) << gnt : '0;
  assign bus.alu_x = x_q;
  assign bus.alu_y = y_q;
  assign bus.alu_ctrl = ctrl_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id = id_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_zr = zr_q;
  assign bus.rsp_ng = ng_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table plus response scoreboard for alu_share_arbiter
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int errs = 0;
  int checks = 0;
  int pops = 0;
  typedef struct { logic [2:0] id; logic [15:0] data; logic zr; logic ng; } rsp_t;
  typedef struct { int id; logic [15:0] x; logic [15:0] y; logic [5:0] c; logic [15:0] e; logic zr; logic ng; } vec_t;
  rsp_t sbq[$];
  rsp_t mon_e;
  vec_t vt[9];
  alu_share_arbiter_if #(.NREQ(4)) b1();
  alu_share_arbiter_if #(.NREQ(4)) b3();
  alu_share_arbiter #(.NREQ(4), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_share_arbiter #(.NREQ(4), .SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  function automatic logic [17:0] hack(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    a = c[4] ? ~a : a;
    b = c[3] ? 16'h0 : y;
    b = c[2] ? ~b : b;
    o = c[1] ? a + b : a & b;
    o = c[0] ? ~o : o;
    return {o == 16'h0, o[15], o};
  endfunction
  assign {b1.alu_zr, b1.alu_ng, b1.alu_out} = hack(b1.alu_x, b1.alu_y, b1.alu_ctrl);
  assign {b3.alu_zr, b3.alu_ng, b3.alu_out} = hack(b3.alu_x, b3.alu_y, b3.alu_ctrl);
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && b1.rsp_valid && b1.rsp_ready) begin
    if (sbq.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL unexpected rsp: got id %0d data %0h expected none", b1.rsp_id, b1.rsp_data);
    end else begin
      mon_e = sbq.pop_front();
      chk("rsp_id", 32'(b1.rsp_id), 32'(mon_e.id));
      chk("rsp_data", 32'(b1.rsp_data), 32'(mon_e.data));
      chk("rsp_zr", 32'(b1.rsp_zr), 32'(mon_e.zr));
      chk("rsp_ng", 32'(b1.rsp_ng), 32'(mon_e.ng));
    end
    pops++;
  end
  task automatic set_req(input int id, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    b1.req_x[16*id +: 16] = x;
    b1.req_y[16*id +: 16] = y;
    b1.req_ctrl[6*id +: 6] = c;
  endtask
  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                       input logic [15:0] e, input logic ez, input logic en);
    int n;
    set_req(id, x, y, c);
    b1.req_valid[id] = 1'b1;
    sbq.push_back('{3'(id), e, ez, en});
    n = 0;
    #1;
    while (!b1.req_ready[id] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready onehot", 32'(b1.req_ready), 32'(4'b1 << id));
    @(posedge clk);
    #1;
    b1.req_valid[id] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("exec alu_x", 32'(b1.alu_x), 32'(x));
        chk("exec alu_y", 32'(b1.alu_y), 32'(y));
        chk("exec alu_ctrl", 32'(b1.alu_ctrl), 32'(c));
      end
    end while (!b1.rsp_valid && n < 20);
    chk("latency", n, 2);
  endtask
  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pops < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("response count", pops, target);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    int p;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p;
    vt[0] = '{0, 16'h0005, 16'h0003, 6'b000010, 16'h0008, 1'b0, 1'b0};
    vt[1] = '{2, 16'h00FF, 16'h0000, 6'b001101, 16'hFF00, 1'b0, 1'b1};
    vt[2] = '{2, 16'h00FF, 16'h0000, 6'b101010, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{1, 16'h0007, 16'h0009, 6'b010011, 16'hFFFE, 1'b0, 1'b1};
    vt[4] = '{3, 16'h0009, 16'h0007, 6'b010011, 16'h0002, 1'b0, 1'b0};
    vt[5] = '{1, 16'h1234, 16'h00FF, 6'b000000, 16'h0034, 1'b0, 1'b0};
    vt[6] = '{3, 16'h0000, 16'h0000, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
    vt[7] = '{0, 16'h0005, 16'h0000, 6'b011111, 16'h0006, 1'b0, 1'b0};
    vt[8] = '{2, 16'h0003, 16'h000A, 6'b000111, 16'h0007, 1'b0, 1'b0};
    rst_n = 1'b0;
    b1.req_valid = 4'hF;
    b1.req_x = '0;
    b1.req_y = '0;
    b1.req_ctrl = '0;
    b1.rsp_ready = 1'b1;
    b3.req_valid = '0;
    b3.req_x = '0;
    b3.req_y = '0;
    b3.req_ctrl = '0;
    b3.rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(b1.req_ready), 0);
    chk("reset alu", {b1.alu_x, b1.alu_ctrl}, 0);
    chk("reset rsp", {b1.rsp_valid, b1.rsp_id, b1.rsp_data, b1.rsp_zr, b1.rsp_ng}, 0);
    chk("reset busy", 32'(b1.busy), 0);
    b1.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(b1.busy), 0);
    for (int i = 0; i < 9; i++) begin
      issue(vt[i].id, vt[i].x, vt[i].y, vt[i].c, vt[i].e, vt[i].zr, vt[i].ng);
      @(posedge clk);
      @(negedge clk);
      chk("idle alu cleared", {b1.alu_x, b1.alu_y, b1.alu_ctrl}, 0);
      chk("idle busy after rsp", 32'(b1.busy), 0);
    end
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'h0010 + 16'(i), 16'h0, 6'b001100);
    p = pops;
    for (int i = 0; i < 5; i++) sbq.push_back('{3'(i % 4), 16'h0010 + 16'(i % 4), 1'b0, 1'b0});
    b1.req_valid = 4'hF;
    wait_pops(p + 5);
    b1.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rr queue drained", sbq.size(), 0);
    do_reset();
    p = pops;
    sbq.push_back('{3'd0, 16'h0010, 1'b0, 1'b0});
    sbq.push_back('{3'd2, 16'h0012, 1'b0, 1'b0});
    sbq.push_back('{3'd3, 16'h0013, 1'b0, 1'b0});
    sbq.push_back('{3'd0, 16'h0010, 1'b0, 1'b0});
    b1.req_valid = 4'hF;
    @(posedge clk);
    #1;
    b1.req_valid[1] = 1'b0;
    wait_pops(p + 4);
    b1.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("skip queue drained", sbq.size(), 0);
    b1.rsp_ready = 1'b0;
    p = pops;
    issue(1, 16'h0100, 16'h0023, 6'b000010, 16'h0123, 1'b0, 1'b0);
    set_req(2, 16'h0042, 16'h0, 6'b001100);
    b1.req_valid[2] = 1'b1;
    sbq.push_back('{3'd2, 16'h0042, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp_valid", 32'(b1.rsp_valid), 1);
      chk("bp rsp_data", {b1.rsp_id, b1.rsp_zr, b1.rsp_ng, b1.rsp_data}, {3'd1, 2'b00, 16'h0123});
      chk("bp req_ready", 32'(b1.req_ready), 0);
    end
    @(posedge clk);
    #1;
    b1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("grant after handshake", 32'(b1.req_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    b1.req_valid[2] = 1'b0;
    wait_pops(p + 2);
    @(negedge clk);
    issue(2, 16'h0001, 16'h0001, 6'b000010, 16'h0002, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_req(3, 16'hABCD, 16'h0001, 6'b000010);
    b1.req_valid[3] = 1'b1;
    #1;
    chk("pre-reset grant", 32'(b1.req_ready), 32'(4'b1000));
    @(posedge clk);
    #1;
    b1.req_valid[3] = 1'b0;
    #1;
    chk("pre-reset exec alu_x", 32'(b1.alu_x), 32'(16'hABCD));
    rst_n = 1'b0;
    #1;
    chk("mid reset alu", {b1.alu_x, b1.alu_y, b1.alu_ctrl}, 0);
    chk("mid reset busy", {b1.busy, b1.rsp_valid, b1.req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset idle", {b1.busy, b1.rsp_valid}, 0);
    p = pops;
    set_req(0, 16'h0020, 16'h0022, 6'b000010);
    sbq.push_back('{3'd0, 16'h0042, 1'b0, 1'b0});
    b1.req_valid = 4'b1001;
    #1;
    chk("post reset first grant", 32'(b1.req_ready), 32'(4'b0001));
    @(posedge clk);
    #1;
    b1.req_valid = '0;
    wait_pops(p + 1);
    @(negedge clk);
    b3.req_x[15:0] = 16'h1357;
    b3.req_y[15:0] = 16'h2468;
    b3.req_ctrl[5:0] = 6'b111010;
    b3.req_valid[0] = 1'b1;
    #1;
    chk("s3 req_ready", 32'(b3.req_ready), 1);
    @(posedge clk);
    #1;
    b3.req_valid[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("s3 alu hold", {b3.alu_ctrl, b3.alu_x, b3.alu_y}, {6'b111010, 16'h1357, 16'h2468});
      chk("s3 rsp_valid low", 32'(b3.rsp_valid), 0);
    end
    @(negedge clk);
    chk("s3 rsp_valid", 32'(b3.rsp_valid), 1);
    chk("s3 rsp", {b3.rsp_id, b3.rsp_zr, b3.rsp_ng, b3.rsp_data}, {3'd0, 2'b01, 16'hFFFF});
    repeat (3) @(negedge clk);
    chk("scoreboard empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Time-shares one structural 16-bit Hack ALU (the Not16/And16/Add16-based datapath) among NREQ requesters.
- Arbitration is round-robin.
- Each requester presents x, y and the 6 Hack control bits (zx,nx,zy,ny,f,no) over a valid/ready handshake.
- The block drives the shared ALU, holds its inputs stable for SETTLE cycles, registers out/zr/ng, and returns the result with the requester ID over a second valid/ready handshake.

Parameters:
- NREQ, 4, number of requesters; legal 2..8.
- SETTLE, 1, cycles the ALU inputs are held before capture; legal 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_x  in  16*NREQ  x operand; requester i at bits [16i+15:16i].
- req_y  in  16*NREQ  y operand, same packing as req_x.
- req_ctrl  in  6*NREQ  {zx,nx,zy,ny,f,no}; requester i at bits [6i+5:6i].
- alu_x  out  16  to shared ALU x.
- alu_y  out  16  to shared ALU y.
- alu_ctrl  out  6  to shared ALU control bits.
- alu_out  in  16  from shared ALU.
- alu_zr  in  1  from shared ALU.
- alu_ng  in  1  from shared ALU.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  3  index of the served requester.
- rsp_data  out  16  registered alu_out.
- rsp_zr  out  1  registered alu_zr.
- rsp_ng  out  1  registered alu_ng.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rr_ptr=0; settle counter=0; operand, ctrl and ID registers=0; all outputs 0 (req_ready=0, alu_x/alu_y/alu_ctrl=0, rsp_*=0, busy=0). Takes effect immediately, including mid-operation; any in-flight request or pending response is discarded without notice.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first index with req_valid set, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: capture req_x[g], req_y[g], req_ctrl[g] and g; load counter=SETTLE-1; go to EXEC.
  - No req_valid: stay in IDLE; req_ready=0.
  - alu_x/alu_y/alu_ctrl=0 while in IDLE.
- EXEC:
  - alu_x/alu_y/alu_ctrl are driven from the captured registers and are stable for the whole state.
  - req_ready=0.
  - counter>0: decrement.
  - counter==0: on the edge, register alu_out/zr/ng into rsp_data/zr/ng, set rsp_valid=1, set rsp_id=captured g, go to RESP.
- RESP:
  - rsp_* are held stable and req_ready=0.
  - alu_* keep the captured values.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle; rr_ptr=(g+1) mod NREQ; go to IDLE.
  - Before that edge, rsp_ready low holds indefinitely.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid is first high in the cycle after edge T+SETTLE.
  - With SETTLE=1, rsp_valid is high in the cycle following the second edge after acceptance.
  - Minimum issue interval is SETTLE+2 cycles with no back-to-back accept in RESP.
- Requester protocol rules:
  - Requesters must hold valid and operands until ready.
  - Operands changing after acceptance have no effect.
  - A requester deasserting valid before grant is simply not served.
- Wrap-around: rr_ptr increments modulo NREQ (NREQ-1 → 0). Bits of rsp_id above clog2(NREQ) are 0.
- rr_ptr updates only on response handshake, never on grant.

Test Plan:
- Add, requester 0: req0 x=0x0005, y=0x0003, ctrl=000010, rsp_ready=1 → req_ready=0001 same cycle; alu_ctrl=000010 during EXEC; rsp_data=0x0008, zr=0, ng=0, rsp_id=0; rsp_valid appears SETTLE+1 cycles after accept.
- Not x, requester 2: req2 x=0x00FF, ctrl=001101 → rsp_data=0xFF00, ng=1, zr=0, rsp_id=2. Same request with ctrl=101010 (constant 0) → rsp_data=0x0000, zr=1.
- Round-robin after reset: all four req_valid held high with distinct x → rsp_id sequence 0,1,2,3,0. Drop req1 before its turn → sequence 0,2,3,0.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_data/id/zr/ng stable, rsp_valid stays 1, req_ready stays 0 despite pending valids; releasing rsp_ready → next grant one cycle after the handshake.
- SETTLE=3 build: alu_x/alu_y/alu_ctrl held for exactly 3 EXEC cycles; rsp_valid first high 4 cycles after accept; -1 op (ctrl=111010) → rsp_data=0xFFFF, ng=1.
- Reset mid-EXEC: rst_n pulsed low asynchronously between edges → all outputs 0 immediately; after release an idle cycle shows busy=0, and requester 0 is granted first.
